instr_fetch_stage: RTL and testbench



---
 rtl/instr_fetch_stage_if.sv | 21 ++
 rtl/instr_fetch_stage.sv | 86 ++++++++
 tb/tb_instr_fetch_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: fetch-stage handshake bundle (control, instruction memory, IF/ID register)
interface instr_fetch_stage_if #(parameter int ADDR_W = 12);
  logic stall;
  logic redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0] imem_rdata;
  logic imem_rvalid;
  logic [15:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic instr_valid;
  modport master (
    input stall, redirect, redirect_pc, imem_rdata, imem_rvalid,
    output imem_req, imem_addr, instr_out, pc_out, instr_valid
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_rdata, imem_rvalid,
    input imem_req, imem_addr, instr_out, pc_out, instr_valid
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: owns the PC, keeps one fetch in flight and drives the IF/ID register
module instr_fetch_stage #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0] BUBBLE = 16'hC000
) (
  input logic clk,
  input logic rst,
  instr_fetch_stage_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext, fetchPc, fetchPcNext, holdPc, holdPcNext;
  logic [ADDR_W-1:0] addrNext, pcOutNext, srcPc, issuePc;
  logic [15:0] holdInstr, holdInstrNext, instrNext, srcInstr;
  logic reqNext, validNext, deliver;
  // a delivery comes either straight from memory or from the hold buffer
  assign srcPc = state == S_HOLD ? holdPc : fetchPc;
  assign srcInstr = state == S_HOLD ? holdInstr : bus.imem_rdata;
  assign issuePc = srcPc + ADDR_W'(1);
  assign deliver = !bus.redirect && !bus.stall && (state == S_HOLD || (state == S_WAIT && bus.imem_rvalid));
  always_comb begin
    stateNext = state;
    pcNext = pc;
    fetchPcNext = fetchPc;
    holdPcNext = holdPc;
    holdInstrNext = holdInstr;
    reqNext = 1'b0;
    addrNext = bus.imem_addr;
    instrNext = bus.stall ? bus.instr_out : BUBBLE;
    pcOutNext = bus.pc_out;
    validNext = bus.stall & bus.instr_valid;
    if (bus.redirect) begin
      instrNext = BUBBLE;
      validNext = 1'b0;
      pcNext = bus.redirect_pc;
      holdInstrNext = BUBBLE;
      stateNext = ((state == S_WAIT || state == S_DROP) && !bus.imem_rvalid) ? S_DROP : S_IDLE;
    end else if (deliver) begin
      instrNext = srcInstr;
      pcOutNext = srcPc;
      validNext = 1'b1;
      pcNext = issuePc;
      fetchPcNext = issuePc;
      reqNext = 1'b1;
      addrNext = issuePc;
      stateNext = S_WAIT;
    end else if (state == S_IDLE) begin
      reqNext = 1'b1;
      addrNext = pc;
      fetchPcNext = pc;
      stateNext = S_WAIT;
    end else if (state == S_WAIT && bus.imem_rvalid) begin
      holdInstrNext = bus.imem_rdata;
      holdPcNext = fetchPc;
      stateNext = S_HOLD;
    end else if (state == S_DROP && bus.imem_rvalid) begin
      stateNext = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      fetchPc <= RESET_PC;
      holdPc <= '0;
      holdInstr <= BUBBLE;
      bus.imem_req <= 1'b0;
      bus.imem_addr <= '0;
      bus.instr_out <= BUBBLE;
      bus.pc_out <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      fetchPc <= fetchPcNext;
      holdPc <= holdPcNext;
      holdInstr <= holdInstrNext;
      bus.imem_req <= reqNext;
      bus.imem_addr <= addrNext;
      bus.instr_out <= instrNext;
      bus.pc_out <= pcOutNext;
      bus.instr_valid <= validNext;
    end
  end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: vector table, corner sequences and random traffic against a transaction-level fetch model
module tb_instr_fetch_stage;
  localparam int AW = 12;
  localparam logic [15:0] BUB = 16'hC000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_stage_if #(.ADDR_W(AW)) bus();
  instr_fetch_stage #(.ADDR_W(AW), .RESET_PC(12'h000), .BUBBLE(BUB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  typedef struct {
    logic s;
    logic r;
    logic [AW-1:0] rpc;
    logic req;
    logic [AW-1:0] addr;
    logic [15:0] instr;
    logic [AW-1:0] pc;
    logic v;
  } vec_t;
  vec_t tbl [17];
  logic [15:0] imem [4096];
  int nChecks = 0, nFail = 0, cnt = 0, lat = 1, deliveries = 0;
  bit randLat = 0;
  logic [AW-1:0] maddr = '0, expPc = '0, mP = '0;
  logic [15:0] mI = BUB;
  logic mV = 1'b0, live = 1'b0, have = 1'b0, lastReq = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: program-order stream of imem words; a returned word is live unless squashed by a redirect
  task automatic step(input logic s, input logic r, input logic [AW-1:0] rpc, input logic rs);
    logic rv;
    @(negedge clk);
    if (bus.imem_req === 1'b1) begin
      chk("req_addr_next_pc", bus.imem_addr, expPc);
      chk("req_single_pulse", lastReq, 0);
      chk("one_outstanding", cnt, 0);
    end
    lastReq = bus.imem_req === 1'b1;
    rv = cnt == 1;
    if (cnt > 0) cnt--;
    if (bus.imem_req === 1'b1) begin
      cnt = randLat ? int'($urandom_range(1, 4)) : lat;
      maddr = bus.imem_addr;
      live = 1'b1;
    end
    if (rs) begin
      cnt = 0;
      rv = 1'b0;
    end
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = rpc;
    rst = rs;
    bus.imem_rvalid = rv;
    bus.imem_rdata = rv ? imem[maddr] : 16'($urandom);
    @(posedge clk);
    #1;
    if (rs) begin
      mI = BUB; mP = '0; mV = 1'b0; live = 1'b0; have = 1'b0; expPc = 12'h000;
      chk("reset_req", bus.imem_req, 0);
    end else if (r) begin
      mI = BUB; mV = 1'b0; live = 1'b0; have = 1'b0; expPc = rpc;
    end else if (rv && live && s) begin
      live = 1'b0; have = 1'b1;
    end else if ((rv && live) || (have && !s)) begin
      mI = imem[expPc]; mP = expPc; mV = 1'b1; expPc++;
      live = 1'b0; have = 1'b0; deliveries++;
    end else if (!s) begin
      mI = BUB; mV = 1'b0;
    end
    chk("ifid_instr", bus.instr_out, mI);
    chk("ifid_pc", bus.pc_out, mP);
    chk("ifid_valid", bus.instr_valid, mV);
  endtask

  task automatic doReset();
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic waitReq(input string name);
    for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) step(1'b0, 1'b0, '0, 1'b0);
    chk(name, bus.imem_req, 1);
  endtask

  task automatic waitRv(input logic s);
    for (int i = 0; i < 20 && cnt != 1; i++) step(s, 1'b0, '0, 1'b0);
    chk("rvalid_due", cnt, 1);
  endtask

  task automatic waitValid(input string name);
    for (int i = 0; i < 20 && bus.instr_valid !== 1'b1; i++) step(1'b0, 1'b0, '0, 1'b0);
    chk(name, bus.instr_valid, 1);
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    for (int i = 0; i < 4096; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h0123; imem[1] = 16'h1456; imem[2] = 16'h2789; imem[3] = 16'h3ABC;
    imem[4] = 16'h4DEF; imem[12'h040] = 16'h7040; imem[12'hFFF] = 16'h9005;
    tbl = '{
      '{1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b0, 1'b0, 12'h000, 1'b1, 12'h001, 16'h0123, 12'h000, 1'b1},
      '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 16'h1456, 12'h001, 1'b1},
      '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 16'h2789, 12'h002, 1'b1},
      '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 16'h2789, 12'h002, 1'b1},
      '{1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 16'h3ABC, 12'h003, 1'b1},
      '{1'b0, 1'b1, 12'h040, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b0, 1'b0, 12'h000, 1'b1, 12'h040, 16'hC000, 12'h000, 1'b0},
      '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 16'hC000, 12'h000, 1'b0},
      '{1'b0, 1'b0, 12'h000, 1'b1, 12'h041, 16'h7040, 12'h040, 1'b1}
    };
    lat = 1;
    doReset();
    chk("reset_instr", bus.instr_out, BUB);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].s, tbl[i].r, tbl[i].rpc, 1'b0);
      chk($sformatf("vec%0d_req", i), bus.imem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("vec%0d_addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_instr", i), bus.instr_out, tbl[i].instr);
      if (tbl[i].v) chk($sformatf("vec%0d_pc", i), bus.pc_out, tbl[i].pc);
      chk($sformatf("vec%0d_valid", i), bus.instr_valid, tbl[i].v);
    end
    // redirect while a latency-3 fetch is still in flight
    doReset();
    lat = 3;
    waitReq("lat3_req");
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 12'h040, 1'b0);
    waitReq("drop_then_req");
    chk("drop_req_addr", bus.imem_addr, 12'h040);
    // redirect in the same cycle as the response
    lat = 2;
    waitRv(1'b0);
    step(1'b0, 1'b1, 12'h123, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rv_redirect_req", bus.imem_req, 1);
    chk("rv_redirect_addr", bus.imem_addr, 12'h123);
    // redirect while holding a stalled instruction
    lat = 1;
    waitRv(1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 12'h200, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("hold_redirect_req", bus.imem_req, 1);
    chk("hold_redirect_addr", bus.imem_addr, 12'h200);
    waitValid("hold_redirect_deliver");
    chk("hold_redirect_pc", bus.pc_out, 12'h200);
    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 12'hFFF, 1'b0);
    waitValid("wrap_deliver");
    chk("wrap_instr", bus.instr_out, 16'h9005);
    chk("wrap_pc", bus.pc_out, 12'hFFF);
    chk("wrap_req", bus.imem_req, 1);
    chk("wrap_addr", bus.imem_addr, 12'h000);
    // reset while waiting and stalled
    doReset();
    lat = 3;
    waitReq("pre_rst_req");
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("midrst_instr", bus.instr_out, BUB);
    chk("midrst_valid", bus.instr_valid, 0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("restart_req", bus.imem_req, 1);
    chk("restart_addr", bus.imem_addr, 12'h000);
    // random traffic
    randLat = 1;
    deliveries = 0;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) == 0 ? 12'hFFF : 12'($urandom), $urandom_range(0, 199) == 0);
    chk("random_progress", deliveries > 100, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
